// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: memory op codes, FSM
// state encodings and the load/store instruction opcodes.
package dm_responder_pkg;

    localparam logic [4:0] MEMOP_S_SW = 5'd0;
    localparam logic [4:0] MEMOP_S_SB = 5'd1;
    localparam logic [4:0] MEMOP_S_SH = 5'd2;

    localparam logic [4:0] MEMOP_L_LW  = 5'd0;
    localparam logic [4:0] MEMOP_L_LBU = 5'd1;
    localparam logic [4:0] MEMOP_L_LHU = 5'd2;
    localparam logic [4:0] MEMOP_L_LB  = 5'd3;
    localparam logic [4:0] MEMOP_L_LH  = 5'd4;

    typedef logic [1:0] stateT;

    localparam stateT ST_IDLE = 2'd0;
    localparam stateT ST_WAIT = 2'd1;
    localparam stateT ST_RESP = 2'd2;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic: store byte enables and merge, load lane
// extraction with zero/sign extension, and alignment/op-code error decode.
module dm_lane_unit
    import dm_responder_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  opS,
    input  logic [4:0]  opL,
    input  logic [31:0] oldWord,
    output logic [31:0] newWord,
    output logic [31:0] rdata,
    output logic        err
);

    logic [3:0]  byteEn;
    logic [31:0] wdataRep;
    logic [15:0] lane;

    always_comb begin
        byteEn   = 4'b0000;
        wdataRep = wdata;
        err      = 1'b0;
        if (we) begin
            case (opS)
                MEMOP_S_SW: begin
                    byteEn = 4'b1111;
                    err    = (addr != 2'd0);
                end
                MEMOP_S_SB: begin
                    byteEn   = 4'b0001 << addr;
                    wdataRep = {4{wdata[7:0]}};
                end
                MEMOP_S_SH: begin
                    byteEn   = addr[1] ? 4'b1100 : 4'b0011;
                    wdataRep = {2{wdata[15:0]}};
                    err      = addr[0];
                end
                default: err = 1'b1;
            endcase
            if (err) begin
                byteEn = 4'b0000;
            end
        end else begin
            case (opL)
                MEMOP_L_LW:               err = (addr != 2'd0);
                MEMOP_L_LHU, MEMOP_L_LH:  err = addr[0];
                MEMOP_L_LBU, MEMOP_L_LB:  err = 1'b0;
                default:                  err = 1'b1;
            endcase
        end
    end

    always_comb begin
        newWord = oldWord;
        for (int k = 0; k < 4; k++) begin
            if (byteEn[k]) begin
                newWord[8*k +: 8] = wdataRep[8*k +: 8];
            end
        end
    end

    // Shifting by the byte offset puts the addressed lane(s) at bit 0.
    always_comb begin
        lane  = 16'(oldWord >> {addr, 3'b000});
        rdata = 32'd0;
        case (opL)
            MEMOP_L_LW:  rdata = oldWord;
            MEMOP_L_LBU: rdata = {24'd0, lane[7:0]};
            MEMOP_L_LHU: rdata = {16'd0, lane};
            MEMOP_L_LB:  rdata = {{24{lane[7]}}, lane[7:0]};
            MEMOP_L_LH:  rdata = {{16{lane[15]}}, lane};
            default:     rdata = 32'd0;
        endcase
        if (we || err) begin
            rdata = 32'd0;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states, then a
// single-cycle response pulse. Stores commit and loads sample on the edge entering RESP.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_op_s,
    input  logic [4:0]  req_op_l,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] resp_pc
);

    localparam int CNT_BITS = $clog2(WAIT_CYCLES + 2);

    stateT                state;
    stateT                stateNext;
    logic [CNT_BITS-1:0]  waitCnt;
    logic [CNT_BITS-1:0]  waitCntNext;

    logic                 capWe;
    logic [ADDR_BITS+1:0] capAddr;
    logic [31:0]          capWdata;
    logic [4:0]           capOpS;
    logic [4:0]           capOpL;
    logic [31:0]          capPc;

    logic [31:0]          rdataQ;
    logic                 errQ;
    logic [31:0]          mem [DEPTH_WORDS];

    logic                 accept;
    logic                 enterResp;
    logic                 inIdle;
    logic                 selWe;
    logic [ADDR_BITS+1:0] selAddr;
    logic [31:0]          selWdata;
    logic [4:0]           selOpS;
    logic [4:0]           selOpL;
    logic [ADDR_BITS-1:0] wordIdx;
    logic [31:0]          oldWord;
    logic [31:0]          newWord;
    logic [31:0]          laneRdata;
    logic                 laneErr;
    logic                 unusedAddrHi;

    assign unusedAddrHi = ^req_addr[31:ADDR_BITS+2];

    assign inIdle     = (state == ST_IDLE);
    assign accept     = inIdle && req_valid;
    assign req_ready  = inIdle;
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdataQ;
    assign resp_err   = errQ;
    assign resp_pc    = capPc;

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    waitCntNext = CNT_BITS'(WAIT_CYCLES);
                    stateNext   = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                waitCntNext = waitCnt - 1'b1;
                if (waitCnt == CNT_BITS'(1)) begin
                    stateNext = ST_RESP;
                end
            end
            ST_RESP: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    assign enterResp = (stateNext == ST_RESP) && (state != ST_RESP);

    // With zero wait states the commit edge is the accept edge, so the lane
    // unit must see the live request rather than the not-yet-captured copy.
    assign selWe    = inIdle ? req_we                  : capWe;
    assign selAddr  = inIdle ? req_addr[ADDR_BITS+1:0] : capAddr;
    assign selWdata = inIdle ? req_wdata               : capWdata;
    assign selOpS   = inIdle ? req_op_s                : capOpS;
    assign selOpL   = inIdle ? req_op_l                : capOpL;
    assign wordIdx  = selAddr[ADDR_BITS+1:2];
    assign oldWord  = mem[wordIdx];

    dm_lane_unit laneUnit (
        .we      (selWe),
        .addr    (selAddr[1:0]),
        .wdata   (selWdata),
        .opS     (selOpS),
        .opL     (selOpL),
        .oldWord (oldWord),
        .newWord (newWord),
        .rdata   (laneRdata),
        .err     (laneErr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            waitCnt  <= '0;
            capWe    <= 1'b0;
            capAddr  <= '0;
            capWdata <= 32'd0;
            capOpS   <= 5'd0;
            capOpL   <= 5'd0;
            capPc    <= 32'd0;
            rdataQ   <= 32'd0;
            errQ     <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (accept) begin
                capWe    <= req_we;
                capAddr  <= req_addr[ADDR_BITS+1:0];
                capWdata <= req_wdata;
                capOpS   <= req_op_s;
                capOpL   <= req_op_l;
                capPc    <= req_pc;
            end
            if (enterResp) begin
                rdataQ <= laneRdata;
                errQ   <= laneErr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (enterResp && selWe && !laneErr) begin
            mem[wordIdx] <= newWord;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed lane/error vectors, randomized
// traffic against a byte-array reference model, back-to-back handshake and reset.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid0;
    logic        reqValid1;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [4:0]  reqOpS;
    logic [4:0]  reqOpL;
    logic [31:0] reqPc;

    logic        ready0, respValid0, err0;
    logic [31:0] rdata0, rpc0;
    logic        ready1, respValid1, err1;
    logic [31:0] rdata1, rpc1;

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0] refMem [4096];

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .ADDR_BITS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid0),
        .req_ready  (ready0),
        .req_we     (reqWe),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .req_op_s   (reqOpS),
        .req_op_l   (reqOpL),
        .req_pc     (reqPc),
        .resp_valid (respValid0),
        .resp_rdata (rdata0),
        .resp_err   (err0),
        .resp_pc    (rpc0)
    );

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .ADDR_BITS(10)) dutW0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid1),
        .req_ready  (ready1),
        .req_we     (reqWe),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .req_op_s   (reqOpS),
        .req_op_l   (reqOpL),
        .req_pc     (reqPc),
        .resp_valid (respValid1),
        .resp_rdata (rdata1),
        .resp_err   (err1),
        .resp_pc    (rpc1)
    );

    // Reference: memory as 4 KiB of bytes; accesses assembled byte by byte.
    function automatic void refAccess(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [4:0] opS,
                                      input logic [4:0] opL, output logic [31:0] rdata,
                                      output logic err);
        int     size;
        int     base;
        bit     sgn;
        longint val;
        rdata = 32'd0;
        err   = 1'b0;
        base  = int'(addr & 32'hFFF);
        if (we) begin
            if (opS > 5'd2) begin err = 1'b1; return; end
            size = (opS == 5'd0) ? 4 : (opS == 5'd1) ? 1 : 2;
            if (base % size != 0) begin err = 1'b1; return; end
            for (int b = 0; b < size; b++) refMem[base + b] = 8'(wdata >> (8 * b));
        end else begin
            if (opL > 5'd4) begin err = 1'b1; return; end
            size = (opL == 5'd0) ? 4 : (opL == 5'd1 || opL == 5'd3) ? 1 : 2;
            sgn  = (opL == 5'd3 || opL == 5'd4);
            if (base % size != 0) begin err = 1'b1; return; end
            val = 0;
            for (int b = 0; b < size; b++) val += longint'(refMem[base + b]) << (8 * b);
            if (sgn && val >= (longint'(1) << (8 * size - 1))) val -= longint'(1) << (8 * size);
            rdata = 32'(val);
        end
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] opS, input logic [4:0] opL, input logic [31:0] pc,
                         output logic [31:0] rdata, output logic err, output logic [31:0] rpc,
                         output int lat, output logic pulseAfter);
        @(negedge clk);
        reqValid0 = 1'b1;
        reqWe     = we;
        reqAddr   = addr;
        reqWdata  = wdata;
        reqOpS    = opS;
        reqOpL    = opL;
        reqPc     = pc;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs while busy; they must not affect the request in flight.
        reqValid0 = 1'b0;
        reqWe     = 1'($urandom);
        reqAddr   = $urandom;
        reqWdata  = $urandom;
        reqOpS    = 5'($urandom);
        reqOpL    = 5'($urandom);
        reqPc     = $urandom;
        lat = 1;
        while (!respValid0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = rdata0;
        err   = err0;
        rpc   = rpc0;
        @(negedge clk);
        pulseAfter = respValid0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        reqWe     = 1'b0;
        reqAddr   = 32'd0;
        reqWdata  = 32'd0;
        reqOpS    = 5'd0;
        reqOpL    = 5'd0;
        reqPc     = 32'd0;
        for (int i = 0; i < 4096; i++) refMem[i] = 8'd0;
        repeat (2) @(negedge clk);
        nChecks++;
        if ({ready0, respValid0, err0, rdata0, rpc0} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0})
            $display("FAIL reset_outputs: got rdy=%b v=%b e=%b d=%h pc=%h want 1 0 0 0 0",
                     ready0, respValid0, err0, rdata0, rpc0);
        else nPass++;
        nChecks++;
        if ({ready1, respValid1} !== 2'b10)
            $display("FAIL reset_outputs_w0: got rdy=%b v=%b want 1 0", ready1, respValid1);
        else nPass++;
        reset = 1'b0;
    endtask

    task automatic runTable(input string tag, input int n, input logic tWe [16],
                            input logic [31:0] tAddr [16], input logic [31:0] tWdata [16],
                            input logic [4:0] tOpS [16], input logic [4:0] tOpL [16],
                            output logic [31:0] gotR [16], output logic gotE [16],
                            output logic [31:0] gotPc [16], output int gotLat [16],
                            output logic gotPulse [16], output logic [31:0] sentPc [16]);
        logic [31:0] mr;
        logic        me;
        for (int i = 0; i < n; i++) begin
            sentPc[i] = $urandom;
            issue(tWe[i], tAddr[i], tWdata[i], tOpS[i], tOpL[i], sentPc[i],
                  gotR[i], gotE[i], gotPc[i], gotLat[i], gotPulse[i]);
            refAccess(tWe[i], tAddr[i], tWdata[i], tOpS[i], tOpL[i], mr, me);
        end
    endtask

    task automatic test_lanes();
        logic        tWe [16];
        logic [31:0] tAddr [16], tWdata [16], expR [16], gotR [16], gotPc [16], sentPc [16];
        logic [4:0]  tOpS [16], tOpL [16];
        logic        expE [16], gotE [16], gotPulse [16];
        int          gotLat [16];
        tWe    = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tAddr  = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h12, 32'h12, 32'h16, 32'h16, 32'h16,
                   32'h14, 0, 0, 0, 0, 0, 0};
        tWdata = '{32'h8765_4321, 0, 32'hAB, 0, 0, 0, 32'h0000_F00D, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tOpS   = '{0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tOpL   = '{0, 0, 0, 0, 3, 1, 0, 4, 2, 0, 0, 0, 0, 0, 0, 0};
        expR   = '{0, 32'h8765_4321, 0, 32'h87AB_4321, 32'hFFFF_FFAB, 32'h0000_00AB, 0,
                   32'hFFFF_F00D, 32'h0000_F00D, 32'hF00D_0000, 0, 0, 0, 0, 0, 0};
        expE   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        runTable("lanes", 10, tWe, tAddr, tWdata, tOpS, tOpL, gotR, gotE, gotPc, gotLat,
                 gotPulse, sentPc);
        for (int i = 0; i < 10; i++) begin
            nChecks++;
            if (gotLat[i] !== 3) $display("FAIL lanes_latency[%0d]: got %0d want 3", i, gotLat[i]);
            else nPass++;
            nChecks++;
            if (gotR[i] !== expR[i])
                $display("FAIL lanes_rdata[%0d]: got %h want %h", i, gotR[i], expR[i]);
            else nPass++;
            nChecks++;
            if (gotE[i] !== expE[i]) $display("FAIL lanes_err[%0d]: got %b want %b", i, gotE[i], expE[i]);
            else nPass++;
            nChecks++;
            if (gotPc[i] !== sentPc[i])
                $display("FAIL lanes_pc[%0d]: got %h want %h", i, gotPc[i], sentPc[i]);
            else nPass++;
            nChecks++;
            if (gotPulse[i] !== 1'b0) $display("FAIL lanes_pulse_width[%0d]: got %b want 0", i, gotPulse[i]);
            else nPass++;
        end
    endtask

    task automatic test_errors_wrap();
        logic        tWe [16];
        logic [31:0] tAddr [16], tWdata [16], expR [16], gotR [16], gotPc [16], sentPc [16];
        logic [4:0]  tOpS [16], tOpL [16];
        logic        expE [16], gotE [16], gotPulse [16];
        int          gotLat [16];
        tWe    = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tAddr  = '{32'h11, 32'h10, 32'h13, 32'h10, 32'h1010, 32'h10, 32'h10, 32'h10, 32'h1012,
                   0, 0, 0, 0, 0, 0, 0};
        tWdata = '{32'hDEAD_BEEF, 0, 0, 0, 32'h55AA_55AA, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0,
                   0, 0};
        tOpS   = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tOpL   = '{0, 0, 4, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        expR   = '{0, 32'h87AB_4321, 0, 0, 0, 32'h55AA_55AA, 0, 32'h55AA_55AA, 32'hAA,
                   0, 0, 0, 0, 0, 0, 0};
        expE   = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        runTable("errors", 9, tWe, tAddr, tWdata, tOpS, tOpL, gotR, gotE, gotPc, gotLat,
                 gotPulse, sentPc);
        for (int i = 0; i < 9; i++) begin
            nChecks++;
            if (gotR[i] !== expR[i])
                $display("FAIL errwrap_rdata[%0d]: got %h want %h", i, gotR[i], expR[i]);
            else nPass++;
            nChecks++;
            if (gotE[i] !== expE[i])
                $display("FAIL errwrap_err[%0d]: got %b want %b", i, gotE[i], expE[i]);
            else nPass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, pc, gotR, gotPc, expR;
        logic [4:0]  opS, opL;
        logic        we, gotE, expE, pulse;
        int          lat;
        for (int i = 0; i < 80; i++) begin
            we    = 1'($urandom);
            addr  = $urandom & 32'hFFFF_F03F;
            wdata = $urandom;
            opS   = 5'($urandom_range(0, 3));
            opL   = 5'($urandom_range(0, 5));
            pc    = $urandom;
            issue(we, addr, wdata, opS, opL, pc, gotR, gotE, gotPc, lat, pulse);
            refAccess(we, addr, wdata, opS, opL, expR, expE);
            nChecks++;
            if (gotR !== expR || gotE !== expE || gotPc !== pc || lat !== 3 || pulse !== 1'b0)
                $display("FAIL random[%0d] we=%b a=%h s=%0d l=%0d: got d=%h e=%b pc=%h lat=%0d p=%b want d=%h e=%b pc=%h lat=3 p=0",
                         i, we, addr, opS, opL, gotR, gotE, gotPc, lat, pulse, expR, expE, pc);
            else nPass++;
        end
    endtask

    task automatic test_back_to_back(input bit sel, input int period);
        int          acceptCyc [$];
        logic [31:0] pcq [$];
        logic [31:0] expPc;
        logic        rdy, vld, rv;
        logic [31:0] rp;
        @(negedge clk);
        reqWe  = 1'b0;
        reqAddr = 32'h10;
        reqOpL = 5'd0;
        reqPc  = $urandom;
        if (sel) reqValid1 = 1'b1; else reqValid0 = 1'b1;
        for (int cyc = 0; cyc < 32; cyc++) begin
            rdy = sel ? ready1 : ready0;
            vld = sel ? reqValid1 : reqValid0;
            rv  = sel ? respValid1 : respValid0;
            rp  = sel ? rpc1 : rpc0;
            if (rv) begin
                expPc = (pcq.size() > 0) ? pcq.pop_front() : ~rp;
                nChecks++;
                if (rp !== expPc) $display("FAIL b2b_pc[w%0d]: got %h want %h", period, rp, expPc);
                else nPass++;
            end
            if (rdy && vld) begin
                acceptCyc.push_back(cyc);
                pcq.push_back(reqPc);
            end
            @(posedge clk);
            #1;
            reqPc = $urandom;
            if (cyc == 23) begin
                if (sel) reqValid1 = 1'b0; else reqValid0 = 1'b0;
            end
            @(negedge clk);
        end
        nChecks++;
        if (acceptCyc.size() !== 24 / period || pcq.size() !== 0)
            $display("FAIL b2b_count[w%0d]: got %0d accepts, %0d unanswered want %0d, 0",
                     period, acceptCyc.size(), pcq.size(), 24 / period);
        else nPass++;
        for (int i = 1; i < acceptCyc.size(); i++) begin
            nChecks++;
            if (acceptCyc[i] - acceptCyc[i-1] !== period)
                $display("FAIL b2b_interval[w%0d]: got %0d want %0d", period,
                         acceptCyc[i] - acceptCyc[i-1], period);
            else nPass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] gotR, gotPc;
        logic        gotE, pulse;
        int          lat;
        bit          sawResp;
        @(negedge clk);
        reqValid0 = 1'b1;
        reqWe     = 1'b1;
        reqAddr   = 32'h20;
        reqWdata  = 32'h1;
        reqOpS    = 5'd0;
        reqPc     = 32'hCAFE_0000;
        @(posedge clk);
        @(negedge clk);
        reqValid0 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        nChecks++;
        if ({ready0, respValid0, err0, rdata0, rpc0} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0})
            $display("FAIL midreset_async: got rdy=%b v=%b e=%b d=%h pc=%h want 1 0 0 0 0",
                     ready0, respValid0, err0, rdata0, rpc0);
        else nPass++;
        sawResp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (respValid0) sawResp = 1'b1;
        end
        reset = 1'b0;
        for (int i = 0; i < 4096; i++) refMem[i] = 8'd0;
        repeat (4) begin
            @(negedge clk);
            if (respValid0) sawResp = 1'b1;
        end
        nChecks++;
        if (sawResp) $display("FAIL midreset_no_resp: got resp_valid=1 want 0");
        else nPass++;
        issue(1'b0, 32'h20, 32'd0, 5'd0, 5'd0, 32'h44, gotR, gotE, gotPc, lat, pulse);
        nChecks++;
        if (gotR !== 32'd0 || gotE !== 1'b0)
            $display("FAIL midreset_lw20: got %h err=%b want 00000000 err=0", gotR, gotE);
        else nPass++;
        issue(1'b0, 32'h10, 32'd0, 5'd0, 5'd0, 32'h48, gotR, gotE, gotPc, lat, pulse);
        nChecks++;
        if (gotR !== 32'd0) $display("FAIL midreset_mem_cleared: got %h want 00000000", gotR);
        else nPass++;
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_errors_wrap();
        test_random();
        test_back_to_back(1'b0, 4);
        test_back_to_back(1'b1, 2);
        test_reset_mid();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
